ram_data_mp: RTL

//  Parametrised, multi-channel data RAM for the multicore datapath. NCORES core ports share one

---
 rtl/ram_data_mp.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ram_data_mp.sv
// Multi-core data RAM: NCORES request/acknowledge ports share one single-port
// synchronous storage array through a round-robin arbiter. One access is made per
// clock, read data is registered, and addresses outside the implemented depth are
// flagged with ERR.
module ram_data_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4096,
    parameter int NCORES = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NCORES-1:0]          RD,
    input  logic [NCORES-1:0]          WR,
    input  logic [NCORES*ADDR_W-1:0]   ADDBUS,
    input  logic [NCORES*DATA_W-1:0]   DATAIN,
    output logic [NCORES*DATA_W-1:0]   DATAOUT,
    output logic [NCORES-1:0]          ACK,
    output logic [NCORES-1:0]          ERR
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Depth held one bit wider than the address so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Round-robin search from ptr upward (mod NCORES); returns {valid, index}.
    function automatic logic [PW:0] rr_pick(input logic [NCORES-1:0] elig,
                                            input logic [PW-1:0]     ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = 0; k < NCORES; k++) begin
            idx = (int'(ptr) + k) % NCORES;
            if (!res[PW] && elig[PW'(idx)]) begin
                res = {1'b1, PW'(idx)};
            end
        end
        return res;
    endfunction

    // Pointer value following a grant to core g.
    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
        return PW'((int'(g) + 1) % NCORES);
    endfunction

    logic [NCORES-1:0] w_elig_p0;
    logic [PW:0]       w_pick_p0;
    logic              w_gnt_vld_p0;
    logic [PW-1:0]     w_gnt_p0;
    logic [ADDR_W-1:0] w_addr_p0;
    logic [DATA_W-1:0] w_wdata_p0;
    logic              w_wr_p0;
    logic              w_inrange_p0;
    logic              w_we_p0;
    logic [IW-1:0]     w_idx_p0;

    logic [PW-1:0]     r_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ram_q_p1;
    logic [NCORES-1:0] r_ack_p1;
    logic [NCORES-1:0] r_err_p1;
    logic              r_rd_p1;
    logic              r_oor_p1;
    logic [DATA_W-1:0] r_dout [NCORES];
    logic [DATA_W-1:0] w_rdata_p1;

    // ---- stage p0: arbitration and request selection ----
    // A core in its acknowledge cycle is masked so it cannot be served twice.
    assign w_elig_p0    = (RD | WR) & ~r_ack_p1;
    assign w_pick_p0    = rr_pick(w_elig_p0, r_ptr);
    assign w_gnt_vld_p0 = w_pick_p0[PW];
    assign w_gnt_p0     = w_pick_p0[PW-1:0];

    // Route the granted core's address, data and direction to the array.
    always_comb begin
        w_addr_p0  = '0;
        w_wdata_p0 = '0;
        w_wr_p0    = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_gnt_p0 == PW'(i)) begin
                w_addr_p0  = ADDBUS[i*ADDR_W +: ADDR_W];
                w_wdata_p0 = DATAIN[i*DATA_W +: DATA_W];
                w_wr_p0    = WR[i];
            end
        end
    end

    // Range check uses the full address; only the low bits index the array.
    assign w_inrange_p0 = ({1'b0, w_addr_p0} < DEPTH_L);
    assign w_idx_p0     = w_addr_p0[IW-1:0];
    assign w_we_p0      = rstn & w_gnt_vld_p0 & w_wr_p0 & w_inrange_p0;

    // ---- stage p1: array access and response registers ----
    // Single-port synchronous RAM with registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we_p0) begin
            r_mem[w_idx_p0] <= w_wdata_p0;
        end
        r_ram_q_p1 <= r_mem[w_idx_p0];
    end

    // Acknowledge/error pulses, read flag and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ack_p1 <= '0;
            r_err_p1 <= '0;
            r_rd_p1  <= 1'b0;
            r_oor_p1 <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_ack_p1 <= w_gnt_vld_p0 ? (NCORES'(1) << w_gnt_p0) : '0;
            r_err_p1 <= (w_gnt_vld_p0 && !w_inrange_p0) ? (NCORES'(1) << w_gnt_p0) : '0;
            r_rd_p1  <= w_gnt_vld_p0 & ~w_wr_p0;
            r_oor_p1 <= ~w_inrange_p0;
            if (w_gnt_vld_p0) begin
                r_ptr <= rr_next(w_gnt_p0);
            end
        end
    end

    // Out-of-range reads return zero.
    assign w_rdata_p1 = r_oor_p1 ? '0 : r_ram_q_p1;

    // Per-core hold register captures the read word during its acknowledge cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NCORES; i++) begin
                r_dout[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (r_ack_p1[i] && r_rd_p1) begin
                    r_dout[i] <= w_rdata_p1;
                end
            end
        end
    end

    // Read data appears with ACK (straight from the RAM register), then is held.
    always_comb begin
        DATAOUT = '0;
        for (int i = 0; i < NCORES; i++) begin
            DATAOUT[i*DATA_W +: DATA_W] = (r_ack_p1[i] && r_rd_p1) ? w_rdata_p1 : r_dout[i];
        end
    end

    assign ACK = r_ack_p1;
    assign ERR = r_err_p1;

endmodule
